// File: rtl/pdp8_lp.sv
// pdp8_lp: line-printer IOT device (device code 66) for pdp8_io.
// Buffers characters written by PPC/PLS and hands them to a parallel
// printer port through a setup/strobe/hold/wait handshake on lp_busy.
// Build option: define PDP8_LP_FIFO_EN to use a FIFO_DEPTH-entry circular
// buffer; otherwise a single holding register gives one-character-at-a-time
// teleprinter-style flag behaviour.
module pdp8_lp #(
  parameter int STROBE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iot,
  input  logic [3:0]  state,
  input  logic [11:0] mb,
  input  logic [11:0] io_data_in,
  input  logic [5:0]  io_select,
  output logic        io_selected,
  output logic [11:0] io_data_out,
  output logic        io_data_avail,
  output logic        io_interrupt,
  output logic        io_skip,
  output logic        io_clear_ac,
  output logic [7:0]  lp_data,
  output logic        lp_strobe,
  input  logic        lp_busy
);

`ifdef PDP8_LP_FIFO_EN
  localparam int DEPTH = FIFO_DEPTH;
  localparam int AW    = $clog2(FIFO_DEPTH);
`else
  localparam int DEPTH = 1;
  localparam int AW    = 0;
`endif
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [3:0] STB_LAST = 4'(STROBE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_WAIT
  } lp_state_t;

  lp_state_t       r_state;
  lp_state_t       w_state_nxt;
  logic [3:0]      r_tmr;
  logic [3:0]      w_tmr_nxt;
  logic            r_strobe;
  logic [7:0]      r_data;
  logic            r_busy_s1;
  logic            r_busy_s2;
  logic            r_flag;
  logic            r_push_set;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_after;
  logic [7:0]      w_head;
  logic            w_busy;
  logic            w_act;
  logic            w_pcf;
  logic            w_ppc;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_push_ok;
  logic            w_fill;
  logic            w_flag_set;
  logic            w_flag_clr;
  logic            w_unused;

  // The CPU state, high MB bits and high AC bits are not needed here.
  assign w_unused = ^{state, mb[11:3], io_data_in[11:8]};

  assign io_selected   = (io_select == 6'o66);
  assign io_data_out   = 12'o0;
  assign io_data_avail = 1'b0;
  assign io_clear_ac   = 1'b0;
  assign io_interrupt  = r_flag;
  assign io_skip       = io_selected & mb[0] & r_flag;
  assign lp_data       = r_data;
  assign lp_strobe     = r_strobe;

  assign w_act  = iot & io_selected;
  assign w_pcf  = w_act & mb[1];
  assign w_ppc  = w_act & mb[2];
  assign w_busy = r_busy_s2;

  // A push into a full buffer is only accepted when the head leaves this cycle.
  assign w_full      = (r_cnt == FULL_CNT);
  assign w_push      = w_ppc & (~w_full | w_pop);
  assign w_cnt_after = r_cnt + CW'(w_push) - CW'(w_pop);

  // Room left after a push raises the flag one cycle later; a push that
  // fills the buffer (with no simultaneous pop) drops it.
  assign w_push_ok  = w_push & (w_cnt_after != FULL_CNT);
  assign w_fill     = w_push & ~w_pop & (w_cnt_after == FULL_CNT);
  assign w_flag_set = w_pop | (r_push_set & ~w_fill);
  assign w_flag_clr = w_pcf | w_fill;

  // Two-flop synchronizer for the asynchronous printer busy line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy_s1 <= 1'b0;
      r_busy_s2 <= 1'b0;
    end else begin
      r_busy_s1 <= lp_busy;
      r_busy_s2 <= r_busy_s1;
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cnt <= '0;
    else       r_cnt <= w_cnt_after;
  end

`ifdef PDP8_LP_FIFO_EN
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;

  // Character storage; contents need no reset because the count gates reads.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= io_data_in[7:0];
  end

  // Read/write pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  assign w_head = r_mem[r_rp];
`else
  logic [7:0] r_hold;

  // Single holding register; a same-cycle pop reads the old value.
  always_ff @(posedge clk) begin
    if (w_push) r_hold <= io_data_in[7:0];
  end

  assign w_head = r_hold;
`endif

  // Device flag: set events take priority over PCF and a filling push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flag     <= 1'b1;
      r_push_set <= 1'b0;
    end else begin
      r_push_set <= w_push_ok;
      if (w_flag_set)      r_flag <= 1'b1;
      else if (w_flag_clr) r_flag <= 1'b0;
    end
  end

  // Output FSM state, phase timer, registered strobe and printer data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_tmr    <= 4'd0;
      r_strobe <= 1'b0;
      r_data   <= 8'h00;
    end else begin
      r_state  <= w_state_nxt;
      r_tmr    <= w_tmr_nxt;
      r_strobe <= (w_state_nxt == S_STROBE);
      if (w_pop) r_data <= w_head;
    end
  end

  // Next-state logic: pop in IDLE, one setup cycle, strobe, two hold cycles
  // to let a strobe-induced busy rise reach the synchronizer, then wait.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = 4'd0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_cnt != '0) && !w_busy) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: w_state_nxt = S_STROBE;
      S_STROBE: begin
        if (r_tmr == STB_LAST) w_state_nxt = S_HOLD;
        else                   w_tmr_nxt   = r_tmr + 4'd1;
      end
      S_HOLD: begin
        if (r_tmr == 4'd1) w_state_nxt = S_WAIT;
        else               w_tmr_nxt   = r_tmr + 4'd1;
      end
      S_WAIT: begin
        if (!w_busy) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pdp8_lp.sv
// Testbench for pdp8_lp: directed IOT sequences with a scoreboard of
// characters the printer is expected to receive, checked at each strobe.
module tb_pdp8_lp;
  logic        clk;
  logic        reset;
  logic        iot;
  logic [3:0]  state;
  logic [11:0] mb;
  logic [11:0] io_data_in;
  logic [5:0]  io_select;
  logic        io_selected;
  logic [11:0] io_data_out;
  logic        io_data_avail;
  logic        io_interrupt;
  logic        io_skip;
  logic        io_clear_ac;
  logic [7:0]  lp_data;
  logic        lp_strobe;
  logic        lp_busy;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] sb_q[$];
  logic       prev_strobe = 1'b0;

  pdp8_lp #(.STROBE_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .iot          (iot),
    .state        (state),
    .mb           (mb),
    .io_data_in   (io_data_in),
    .io_select    (io_select),
    .io_selected  (io_selected),
    .io_data_out  (io_data_out),
    .io_data_avail(io_data_avail),
    .io_interrupt (io_interrupt),
    .io_skip      (io_skip),
    .io_clear_ac  (io_clear_ac),
    .lp_data      (lp_data),
    .lp_strobe    (lp_strobe),
    .lp_busy      (lp_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic iot_op(input logic [2:0] fn, input logic [11:0] ac);
    mb         = 12'o6660 | {9'd0, fn};
    io_data_in = ac;
    iot        = 1'b1;
    tick();
    iot        = 1'b0;
    mb         = 12'o0;
    io_data_in = 12'o0;
  endtask

  task automatic wait_drain(input int maxc);
    int c;
    c = 0;
    while (sb_q.size() != 0 && c < maxc) begin
      tick();
      c++;
    end
    check("drain", sb_q.size(), 0);
    repeat (10) tick();
  endtask

  // Printer side: every strobe rise must present the next expected character.
  always @(negedge clk) begin
    if (lp_strobe && !prev_strobe) begin
      if (sb_q.size() == 0) begin
        check("lp_extra", {24'd0, lp_data}, 32'h100);
      end else begin
        check("lp_data", {24'd0, lp_data}, {24'd0, sb_q.pop_front()});
      end
    end
    prev_strobe <= lp_strobe;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset      = 1'b1;
    iot        = 1'b0;
    state      = 4'd0;
    mb         = 12'o0;
    io_data_in = 12'o0;
    io_select  = 6'o66;
    lp_busy    = 1'b0;
    repeat (2) tick();

    // Reset values
    check("rst_int", io_interrupt, 1);
    check("rst_data", lp_data, 0);
    check("rst_strobe", lp_strobe, 0);
    check("rst_dout", io_data_out, 0);
    check("rst_avail", io_data_avail, 0);
    check("rst_clrac", io_clear_ac, 0);
    reset = 1'b0;
    tick();

    // PSF after reset, selected and not selected
    mb = 12'o6661;
    #1;
    check("psf_sel", io_selected, 1);
    check("psf_skip", io_skip, 1);
    io_select = 6'o03;
    #1;
    check("nsel_sel", io_selected, 0);
    check("nsel_skip", io_skip, 0);
    io_select = 6'o66;
    mb = 12'o0;
    tick();

    // PLS 'A' with busy low: data at N+2, 4-cycle strobe, flag low one cycle
    sb_q.push_back(8'h41);
    iot_op(3'd6, 12'o0101);
    check("pls_flag_n1", io_interrupt, 0);
    check("pls_strobe_n1", lp_strobe, 0);
    tick();
    check("pls_data_n2", lp_data, 8'h41);
    check("pls_flag_n2", io_interrupt, 1);
    check("pls_strobe_n2", lp_strobe, 0);
    tick();
    check("pls_strobe_n3", lp_strobe, 1);
    w = 0;
    while (lp_strobe && w < 20) begin
      w++;
      tick();
    end
    check("strobe_width", w, 4);
    repeat (5) tick();
    check("data_hold", lp_data, 8'h41);

    // PCF in the very cycle the FSM pops: set wins
    sb_q.push_back(8'h55);
    iot_op(3'd4, 12'h055);
    iot_op(3'd2, 12'h000);
    check("pcf_vs_pop", io_interrupt, 1);
    wait_drain(40);

`ifdef PDP8_LP_FIFO_EN
    // Busy held: four accepted, flag drops after the fourth, rest discarded
    lp_busy = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) sb_q.push_back(8'h30 + 8'(i));
      iot_op(3'd4, 12'h030 + 12'(i));
      check("fifo_flag", io_interrupt, (i < 3) ? 1 : 0);
    end
    lp_busy = 1'b0;
    wait_drain(100);
    check("fifo_flag_end", io_interrupt, 1);
`else
    // Busy held: 'B' held, 'C' arrives while full and is dropped
    lp_busy = 1'b1;
    repeat (3) tick();
    sb_q.push_back(8'h42);
    iot_op(3'd6, 12'h042);
    check("hold_flag_b", io_interrupt, 0);
    repeat (2) tick();
    iot_op(3'd6, 12'h043);
    check("hold_flag_c", io_interrupt, 0);
    lp_busy = 1'b0;
    wait_drain(100);
    check("hold_flag_end", io_interrupt, 1);
`endif

    // Reset during STROBE with a second character buffered
    sb_q.push_back(8'h77);
    iot_op(3'd4, 12'h077);
    iot_op(3'd4, 12'h078);
    tick();
    check("pre_rst_strobe", lp_strobe, 1);
    #5;
    reset = 1'b1;
    #1;
    check("rst_mid_strobe", lp_strobe, 0);
    check("rst_mid_flag", io_interrupt, 1);
    check("rst_mid_data", lp_data, 0);
    tick();
    reset = 1'b0;
    repeat (20) tick();
    check("rst_no_print", lp_strobe, 0);
    check("sb_left", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pdp8_lp.md
# pdp8_lp

Line-printer IOT device (device code 66) that plugs into `pdp8_io` beside the kw, tt and rf devices. It accepts characters from the AC via IOT instructions and buffers them. It drives them to a parallel printer port with a strobe/busy handshake. It raises a device flag (skip and interrupt) whenever it can take another character.

## Interface
Parameters:
- `STROBE_CYCLES`, default 4: width of `lp_strobe` pulse in `clk` cycles (1..15).
- `FIFO_DEPTH`, default 4: character buffer depth when `PDP8_LP_FIFO_EN` is defined (power of 2, 2..16).

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `iot`  in  1  one-cycle qualifier, high for exactly one `clk` per IOT instruction.
- `state`  in  4  CPU major state; unused, present for uniform device interface.
- `mb`  in  12  memory buffer; `mb[2:0]` is the IOT function.
- `io_data_in`  in  12  AC value; `io_data_in[7:0]` is the character.
- `io_select`  in  6  IOT device field.
- `io_selected`  out  1  combinational: `io_select == 6'o66`.
- `io_data_out`  out  12  always 0.
- `io_data_avail`  out  1  always 0.
- `io_interrupt`  out  1  equals `flag`.
- `io_skip`  out  1  combinational: `io_selected & mb[0] & flag`.
- `io_clear_ac`  out  1  always 0.
- `lp_data`  out  8  printer data, registered.
- `lp_strobe`  out  1  printer strobe, active-high, registered.
- `lp_busy`  in  1  printer busy, asynchronous; synchronized internally (2 flops).

## Operation
- IOT decode, acted on only in the cycle where `iot & io_selected`:
  - 6661 PSF: skip if flag. Combinational only; no state change.
  - 6662 PCF: clear flag.
  - 6664 PPC: push `io_data_in[7:0]` into the buffer.
  - 6666 PLS: PCF and PPC together.
- Bits combine independently.
- Buffer full on push: the character is discarded, and buffer and pointers are unchanged.
- Flag set events:
  - reset (flag resets to 1);
  - a pop by the output FSM;
  - a push that leaves the buffer not full. The flag sets one cycle after the push.
- A set event in the same cycle as PCF wins: flag ends up 1.
- Output FSM states:
  - IDLE: when the buffer is non-empty and synchronized busy is 0, pop the head into `lp_data` and go to SETUP.
  - SETUP: 1 cycle with data stable and strobe low, then go to STROBE.
  - STROBE: `lp_strobe=1` for `STROBE_CYCLES` cycles, then go to HOLD.
  - HOLD: 2 cycles with strobe low, covering synchronizer latency, then go to WAIT.
  - WAIT: stay until synchronized busy is 0, then go to IDLE.
- `lp_data` holds its value until the next pop.
- Push and pop in the same cycle: both take effect and the occupancy is unchanged. This is legal when the buffer is full; the push is accepted.
- Pointers wrap modulo the depth. Occupancy counter width is log2(depth)+1.

## Timing
- Reset values:
  - `flag` = 1, so `io_interrupt` = 1;
  - `lp_data` = 0, `lp_strobe` = 0;
  - buffer empty, FSM in IDLE;
  - `io_data_out` = 0, `io_data_avail` = 0, `io_clear_ac` = 0;
  - `io_skip` follows its combinational equation.
- Reset mid-transfer: strobe drops immediately (asynchronous) and buffered characters are lost.
- PPC on cycle N with empty buffer and busy low:
  - buffer non-empty at N+1;
  - pop and `lp_data` valid at N+2;
  - `lp_strobe` high from N+3 to N+2+`STROBE_CYCLES`.
- Minimum character period with busy held low: 1+1+`STROBE_CYCLES`+2+1 = 9 cycles at default.
- A busy rise caused by the strobe must be seen by the end of HOLD. If it arrives later, the next transfer waits in IDLE, which also checks busy.
- PCF on cycle N: flag reads 0 at N+1, unless a set event occurs in cycle N.

## Configuration
- `PDP8_LP_FIFO_EN` defined: `FIFO_DEPTH`-entry circular buffer; the flag stays set while space remains.
- Undefined:
  - single 8-bit holding register (depth 1);
  - `FIFO_DEPTH` ignored;
  - a push sets the flag only if the pop happens in the same cycle. The flag is otherwise set by the pop, giving teleprinter-style one-character-at-a-time behaviour.

## Test plan
- Reset then PSF (`mb`=12'o6661, `io_select`=6'o66) -> `io_skip`=1, `io_interrupt`=1; with `io_select`=6'o03 -> `io_selected`=0, `io_skip`=0.
- PLS with AC=12'o0101, `lp_busy`=0 -> `lp_data`=8'h41 two cycles later; strobe high exactly 4 cycles; flag clear for one cycle, then 1 (FIFO build).
- Hold `lp_busy`=1, PPC six characters 0x30..0x35 (FIFO build, depth 4):
  - first four accepted; the flag drops one cycle after the fourth;
  - release busy -> printer receives 0x30..0x33 in order, and 0x34/0x35 are never output.
- PCF while the FSM pops in the same cycle -> flag=1 afterward.
- Assert `reset` during STROBE -> `lp_strobe`=0 in the same cycle, buffer empty, flag=1.
- Non-FIFO build:
  - PLS 'A' -> flag returns to 1 at the pop;
  - PLS 'B', then PLS 'C' before the pop of 'B' -> 'C' discarded, printer sees 'A','B' only.
